// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, load/store and memory-side signals of the unified memory port.
// The arbiter connects through the slave modport; the core and memory side use master.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;

  logic              d_req;
  logic              d_we;
  logic [BE_W-1:0]   d_be;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_valid;

  logic              mem_req;
  logic              mem_we;
  logic [BE_W-1:0]   mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_ack, mem_rdata,
    output if_rdata, if_valid, d_rdata, d_valid,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_ack, mem_rdata,
    input  if_rdata, if_valid, d_rdata, d_valid,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port unified memory between fetch and load/store.
// Data wins by default; a bounded data streak keeps fetch moving forward.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_DSTREAK = 4
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus
);
  localparam int BE_W = DATA_W / 8;
  localparam logic [3:0] MAX_S = 4'(MAX_DSTREAK);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IF = 2'd1,
    GNT_D  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t            state_r;
  state_t            next_state_s;
  logic              grant_d_s;
  logic              grant_if_s;
  logic              ack_s;

  logic [3:0]        streak_r;
  logic              mem_req_r;
  logic              mem_we_r;
  logic [BE_W-1:0]   mem_be_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic [DATA_W-1:0] if_rdata_r;
  logic [DATA_W-1:0] d_rdata_r;
  logic              if_valid_r;
  logic              d_valid_r;
  logic              busy_r;

  // mem_ack only counts while a grant is actually outstanding
  assign ack_s = bus.mem_ack && ((state_r == GNT_IF) || (state_r == GNT_D));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and grant decisions
  always_comb begin
    next_state_s = state_r;
    grant_d_s    = 1'b0;
    grant_if_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.d_req && !(bus.if_req && (streak_r == MAX_S))) begin
          next_state_s = GNT_D;
          grant_d_s    = 1'b1;
        end else if (bus.if_req) begin
          next_state_s = GNT_IF;
          grant_if_s   = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      GNT_IF, GNT_D: begin
        if (bus.mem_ack) begin
          next_state_s = DONE;
        end else begin
          next_state_s = state_r;
        end
      end
      DONE: begin
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Memory command, streak counter, read data capture and status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      streak_r    <= 4'd0;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_be_r    <= '0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      if_rdata_r  <= '0;
      d_rdata_r   <= '0;
      if_valid_r  <= 1'b0;
      d_valid_r   <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      if_valid_r <= ack_s && (state_r == GNT_IF);
      d_valid_r  <= ack_s && (state_r == GNT_D);
      busy_r     <= (next_state_s != IDLE);

      if (grant_d_s) begin
        mem_req_r   <= 1'b1;
        mem_we_r    <= bus.d_we;
        mem_be_r    <= bus.d_be;
        mem_addr_r  <= bus.d_addr;
        mem_wdata_r <= bus.d_wdata;
        if (!bus.if_req) begin
          streak_r <= 4'd0;
        end else if (streak_r >= MAX_S) begin
          streak_r <= MAX_S;
        end else begin
          streak_r <= streak_r + 4'd1;
        end
      end else if (grant_if_s) begin
        mem_req_r   <= 1'b1;
        mem_we_r    <= 1'b0;
        mem_be_r    <= '1;
        mem_addr_r  <= bus.if_addr;
        mem_wdata_r <= '0;
        streak_r    <= 4'd0;
      end else if (ack_s) begin
        mem_req_r <= 1'b0;
      end

      if (ack_s && (state_r == GNT_IF)) begin
        if_rdata_r <= bus.mem_rdata;
      end
      // Stores leave the last load data in place
      if (ack_s && (state_r == GNT_D) && !mem_we_r) begin
        d_rdata_r <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_req   = mem_req_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_be    = mem_be_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.if_rdata  = if_rdata_r;
  assign bus.d_rdata   = d_rdata_r;
  assign bus.if_valid  = if_valid_r;
  assign bus.d_valid   = d_valid_r;
  assign bus.busy      = busy_r;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues expected responses,
// a monitor checks each valid pulse against the queue head.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DSTREAK(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    bit          is_d;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  int          ws = 0;
  bit          force_ack = 1'b0;
  bit          rd_fixed_en = 1'b0;
  logic [31:0] rd_fixed = 32'h0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void push(bit is_d, logic [31:0] data);
    exp_t e;
    e.is_d = is_d;
    e.data = data;
    q.push_back(e);
  endfunction

  // Memory model: acks after ws wait cycles, data derived from address unless fixed
  initial begin
    int req_cyc = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (bus.mem_req) req_cyc++;
      else req_cyc = 0;
      bus.mem_ack   = force_ack || (bus.mem_req && (req_cyc == ws + 1));
      bus.mem_rdata = rd_fixed_en ? rd_fixed : (bus.mem_addr ^ 32'h1234_0000);
    end
  end

  // Monitor: every valid pulse must match the scoreboard head
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && (bus.if_valid || bus.d_valid)) begin
        check("valid_overlap", {63'd0, bus.if_valid & bus.d_valid}, 64'd0);
        if (q.size() == 0) begin
          check("spurious_valid", {62'd0, bus.if_valid, bus.d_valid}, 64'd0);
        end else begin
          e = q.pop_front();
          check("grant_kind", {63'd0, bus.d_valid}, {63'd0, e.is_d});
          check("rdata", {32'd0, (e.is_d ? bus.d_rdata : bus.if_rdata)}, {32'd0, e.data});
        end
      end
    end
  end

  task automatic wait_valid(output bit is_d);
    bit seen = 1'b0;
    is_d = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (bus.if_valid || bus.d_valid) begin
        seen = 1'b1;
        is_d = bus.d_valid;
      end
    end
    check("valid_timeout", {63'd0, seen}, 64'd1);
  endtask

  bit got_d;
  bit exp_kind [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [31:0] exp_addr [10] = '{32'h200, 32'h204, 32'h208, 32'h20C, 32'h40,
                                 32'h210, 32'h214, 32'h218, 32'h21C, 32'h44};

  initial begin
    bus.if_req = 1'b0; bus.if_addr = 32'h0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_be = 4'h0;
    bus.d_addr = 32'h0; bus.d_wdata = 32'h0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ctrl", {58'd0, bus.mem_req, bus.mem_we, bus.if_valid, bus.d_valid, bus.busy, 1'b0}, 64'd0);
    check("rst_rdata", {bus.if_rdata, bus.d_rdata}, 64'd0);
    check("rst_mem_bus", {28'd0, bus.mem_be, bus.mem_addr}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // 1: fetch, zero wait
    ws = 0; rd_fixed_en = 1'b1; rd_fixed = 32'h0050_0613;
    push(1'b0, 32'h0050_0613);
    bus.if_addr = 32'h10; bus.if_req = 1'b1;
    @(negedge clk);
    check("t1_mem_req", {63'd0, bus.mem_req}, 64'd1);
    check("t1_mem_addr", {32'd0, bus.mem_addr}, 64'h10);
    check("t1_mem_we_be", {59'd0, bus.mem_we, bus.mem_be}, {59'd0, 1'b0, 4'hF});
    check("t1_busy1", {63'd0, bus.busy}, 64'd1);
    @(negedge clk);
    check("t1_if_valid", {63'd0, bus.if_valid}, 64'd1);
    check("t1_busy2", {63'd0, bus.busy}, 64'd1);
    bus.if_req = 1'b0;
    @(negedge clk);
    check("t1_pulse_end", {62'd0, bus.if_valid, bus.busy}, 64'd0);

    // 6: spurious ack while idle, then load of 0x1
    force_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6_idle", {62'd0, bus.mem_req, bus.busy}, 64'd0);
    end
    force_ack = 1'b0; rd_fixed = 32'h1;
    push(1'b1, 32'h1);
    bus.d_addr = 32'h300; bus.d_we = 1'b0; bus.d_be = 4'hF; bus.d_req = 1'b1;
    wait_valid(got_d);
    bus.d_req = 1'b0;
    @(negedge clk);
    check("t6_d_rdata_hold", {32'd0, bus.d_rdata}, 64'h1);
    rd_fixed_en = 1'b0;

    // 2: store with two wait states; inputs change mid-grant
    ws = 2;
    push(1'b1, 32'h1);
    bus.d_we = 1'b1; bus.d_be = 4'b0011; bus.d_addr = 32'h100; bus.d_wdata = 32'hDEAD_BEEF;
    bus.d_req = 1'b1;
    @(negedge clk);
    bus.d_addr = 32'h999; bus.d_wdata = 32'h0; bus.d_be = 4'hF;
    for (int i = 0; i < 3; i++) begin
      check("t2_hold_ctrl", {58'd0, bus.mem_req, bus.mem_we, bus.mem_be}, {58'd0, 1'b1, 1'b1, 4'b0011});
      check("t2_hold_data", {bus.mem_addr, bus.mem_wdata}, {32'h100, 32'hDEAD_BEEF});
      check("t2_no_valid", {62'd0, bus.d_valid, bus.if_valid}, 64'd0);
      @(negedge clk);
    end
    check("t2_d_valid", {63'd0, bus.d_valid}, 64'd1);
    check("t2_mem_req_drop", {63'd0, bus.mem_req}, 64'd0);
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_be = 4'hF;
    @(negedge clk);
    check("t2_single_pulse", {63'd0, bus.d_valid}, 64'd0);

    // 3: both requesters held high, streak limit 4
    ws = 0;
    for (int k = 0; k < 10; k++) push(exp_kind[k], exp_addr[k] ^ 32'h1234_0000);
    bus.if_addr = 32'h40; bus.d_addr = 32'h200;
    bus.if_req = 1'b1; bus.d_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      wait_valid(got_d);
      check("t3_seq", {63'd0, got_d}, {63'd0, exp_kind[k]});
      if (got_d) bus.d_addr = bus.d_addr + 32'd4;
      else bus.if_addr = bus.if_addr + 32'd4;
      if (k == 9) begin
        bus.if_req = 1'b0; bus.d_req = 1'b0;
      end
    end
    repeat (2) @(negedge clk);

    // 4: simultaneous arrival with streak at 0, data first
    push(1'b1, 32'h1234_0400);
    push(1'b0, 32'h1234_0090);
    bus.d_addr = 32'h400; bus.if_addr = 32'h90;
    bus.d_req = 1'b1; bus.if_req = 1'b1;
    wait_valid(got_d);
    check("t4_first_d", {63'd0, got_d}, 64'd1);
    bus.d_req = 1'b0;
    wait_valid(got_d);
    check("t4_second_if", {63'd0, got_d}, 64'd0);
    bus.if_req = 1'b0;
    repeat (2) @(negedge clk);

    // 5: reset during a fetch grant
    ws = 100;
    bus.if_addr = 32'h80; bus.if_req = 1'b1;
    @(negedge clk);
    check("t5_granted", {63'd0, bus.mem_req}, 64'd1);
    #2 reset = 1'b1;
    #1;
    check("t5_async_clear", {61'd0, bus.mem_req, bus.busy, bus.if_valid}, 64'd0);
    repeat (2) @(negedge clk);
    ws = 0;
    push(1'b0, 32'h1234_0080);
    reset = 1'b0;
    @(negedge clk);
    check("t5_regrant", {31'd0, bus.mem_req, bus.mem_addr}, {31'd0, 1'b1, 32'h80});
    wait_valid(got_d);
    bus.if_req = 1'b0;
    repeat (3) @(negedge clk);

    check("queue_empty", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
